// File: rtl/wb_timer_pkg.sv
// Shared constants, channel record and byte-lane helper for the Wishbone timer.
package wb_timer_pkg;
   localparam int MAX_CHAN = 4;

   localparam logic [3:0] REG_STATUS    = 4'h0;
   localparam logic [3:0] REG_CTRL      = 4'h1;
   localparam logic [3:0] REG_PRESCALE  = 4'h2;
   localparam logic [3:0] REG_COUNT     = 4'h3;
   localparam logic [3:0] REG_CMP0      = 4'h4;
   localparam logic [3:0] REG_INTERVAL0 = 4'h8;

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_IE_LSB  = 4;
   localparam int CTRL_IE_MSB  = 7;
   localparam int CTRL_PER_LSB = 8;
   localparam int CTRL_PER_MSB = 11;

   typedef struct packed {
      logic [31:0] cmp;
      logic [31:0] interval;
      logic        flag;
      logic        ie;
      logic        per;
   } chan_t;

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      for (int b = 0; b < 4; b++)
         res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
      return res;
   endfunction
endpackage

// File: rtl/wb_timer_if.sv
// Wishbone pipelined bus bundle used between the address decoder and the timer.
interface if_wb;
   logic [31:0] adr;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] dat_m;
   logic [31:0] dat_s;
   logic        ack;
   logic        stall;

   modport master (output adr, cyc, stb, we, sel, dat_m, input dat_s, ack, stall);
   modport slave  (input adr, cyc, stb, we, sel, dat_m, output dat_s, ack, stall);
endinterface

// File: rtl/wb_timer_chan.sv
// One compare channel: CMP and INTERVAL registers plus the sticky match flag.
module wb_timer_chan
   import wb_timer_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        tick_i,
   input  logic [31:0] count_next_i,
   input  logic        cmp_we_i,
   input  logic        int_we_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] wdata_i,
   input  logic        clr_i,
   input  logic        ie_i,
   input  logic        per_i,
   output logic        flag_o,
   output chan_t       state_o
);
   logic [31:0] cmp_q, cmp_d, int_q, int_d;
   logic        flag_q, flag_d, match;

   assign match = tick_i && (count_next_i == cmp_q);

   // A match beats a clear; a software CMP write beats a periodic reload.
   always_comb begin
      cmp_d  = cmp_q;
      int_d  = int_q;
      flag_d = flag_q;
      if (cmp_we_i)
         cmp_d = merge_lanes(cmp_q, wdata_i, sel_i);
      else if (match && per_i)
         cmp_d = cmp_q + int_q;
      if (int_we_i)
         int_d = merge_lanes(int_q, wdata_i, sel_i);
      if (match)
         flag_d = 1'b1;
      else if (clr_i)
         flag_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cmp_q  <= '0;
         int_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cmp_q  <= cmp_d;
         int_q  <= int_d;
         flag_q <= flag_d;
      end
   end

   assign flag_o  = flag_q;
   assign state_o = '{cmp: cmp_q, interval: int_q, flag: flag_q, ie: ie_i, per: per_i};
endmodule

// File: rtl/wb_timer.sv
// Wishbone timer top: bus decode, read mux, prescaler, COUNT and the irq register.
module wb_timer
   import wb_timer_pkg::*;
#(
   parameter int NCHAN  = 4,
   parameter int PWIDTH = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   if_wb.slave  bus,
   output logic irq
);
   localparam logic [3:0]  CHAN_MASK = 4'((1 << NCHAN) - 1);
   localparam logic [11:0] CTRL_MASK = {CHAN_MASK, CHAN_MASK, 4'b0001};

   logic              accept, wr;
   logic [3:0]        off;
   logic              wr_status, wr_ctrl, wr_pre, wr_count;
   logic [11:0]       ctrl_q, ctrl_d;
   logic [PWIDTH-1:0] pre_q, pre_d, pc_q, pc_d;
   logic [31:0]       count_q, count_d, count_inc;
   logic [31:0]       ctrl_wr, pre_wr, count_wr;
   logic              pc_hit, tick;
   logic [MAX_CHAN-1:0] flags;
   chan_t             chan_s [MAX_CHAN];
   logic [31:0]       rdata, dat_q;
   logic              ack_q, irq_q;
   logic              unused_bits;

   assign accept    = bus.cyc & bus.stb;
   assign wr        = accept & bus.we;
   assign off       = bus.adr[5:2];
   assign wr_status = wr && (off == REG_STATUS);
   assign wr_ctrl   = wr && (off == REG_CTRL);
   assign wr_pre    = wr && (off == REG_PRESCALE);
   assign wr_count  = wr && (off == REG_COUNT);

   assign ctrl_wr   = merge_lanes({20'd0, ctrl_q}, bus.dat_m, bus.sel);
   assign pre_wr    = merge_lanes(32'(pre_q), bus.dat_m, bus.sel);
   assign count_wr  = merge_lanes(count_q, bus.dat_m, bus.sel);
   assign count_inc = count_q + 32'd1;
   assign pc_hit    = (pc_q == pre_q);

   // Tick uses the post-write EN so that clearing EN suppresses the tick on that edge.
   always_comb begin
      ctrl_d  = ctrl_q;
      pre_d   = pre_q;
      count_d = count_q;
      pc_d    = pc_q + PWIDTH'(1);
      if (wr_ctrl)
         ctrl_d = ctrl_wr[11:0] & CTRL_MASK;
      if (wr_pre)
         pre_d = pre_wr[PWIDTH-1:0];
      tick = ctrl_q[CTRL_EN_BIT] & ctrl_d[CTRL_EN_BIT] & pc_hit;
      if (!ctrl_q[CTRL_EN_BIT] || !ctrl_d[CTRL_EN_BIT] || wr_count || pc_hit)
         pc_d = '0;
      if (wr_count)
         count_d = count_wr;
      else if (tick)
         count_d = count_inc;
   end

   for (genvar gi = 0; gi < MAX_CHAN; gi++) begin : g_chan
      if (gi < NCHAN) begin : g_on
         localparam logic [3:0] CMP_OFF = REG_CMP0 + 4'(gi);
         localparam logic [3:0] INT_OFF = REG_INTERVAL0 + 4'(gi);
         wb_timer_chan u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .tick_i      (tick),
            .count_next_i(count_inc),
            .cmp_we_i    (wr && (off == CMP_OFF)),
            .int_we_i    (wr && (off == INT_OFF)),
            .sel_i       (bus.sel),
            .wdata_i     (bus.dat_m),
            .clr_i       (wr_status & bus.sel[0] & bus.dat_m[gi]),
            .ie_i        (ctrl_q[CTRL_IE_LSB + gi]),
            .per_i       (ctrl_q[CTRL_PER_LSB + gi]),
            .flag_o      (flags[gi]),
            .state_o     (chan_s[gi])
         );
      end else begin : g_off
         assign flags[gi]  = 1'b0;
         assign chan_s[gi] = '0;
      end
   end

   always_comb begin
      rdata = '0;
      case (off[3:2])
         2'b00: begin
            case (off[1:0])
               2'd0:    rdata = {28'd0, flags};
               2'd1:    rdata = {20'd0, ctrl_q};
               2'd2:    rdata = 32'(pre_q);
               default: rdata = count_q;
            endcase
         end
         2'b01:   rdata = chan_s[off[1:0]].cmp;
         2'b10:   rdata = chan_s[off[1:0]].interval;
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ctrl_q  <= '0;
         pre_q   <= '0;
         pc_q    <= '0;
         count_q <= '0;
         ack_q   <= 1'b0;
         dat_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         pre_q   <= pre_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         ack_q   <= accept;
         dat_q   <= (accept && !bus.we) ? rdata : '0;
         irq_q   <= |(flags & ctrl_q[CTRL_IE_MSB:CTRL_IE_LSB]);
      end
   end

   assign bus.ack     = ack_q;
   assign bus.dat_s   = dat_q;
   assign bus.stall   = 1'b0;
   assign irq         = irq_q;
   assign unused_bits = ^{bus.adr[31:6], bus.adr[1:0], ctrl_wr[31:12], pre_wr};
endmodule

// File: tb/tb_wb_timer.sv
// Randomised self-checking bench for wb_timer against a cycle-count arithmetic model.
module tb_wb_timer;
   import wb_timer_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   logic irq;
   int   n_tests = 0;
   int   n_fail  = 0;

   if_wb bus();

   wb_timer #(.NCHAN(4), .PWIDTH(16)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus),
      .irq  (irq)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [31:0] A_STATUS = 32'h00, A_CTRL = 32'h04, A_PRE = 32'h08, A_COUNT = 32'h0C;

   function automatic logic [31:0] a_cmp(input int ch);
      return 32'h10 + 32'(4 * ch);
   endfunction
   function automatic logic [31:0] a_int(input int ch);
      return 32'h20 + 32'(4 * ch);
   endfunction

   // One single-cycle request; called at posedge+1, returns at the next posedge+1.
   task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic ackd);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = a; bus.dat_m = d; bus.sel = s;
      @(posedge clk_i); #1;
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
      rd = bus.dat_s; ackd = bus.ack;
      $display("[TB] %s adr=%h wdat=%h sel=%b -> ack=%b dat_s=%h", we ? "WR" : "RD", a, d, s, ackd, rd);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] rd; logic ackd;
      xfer(1'b1, a, d, 4'hF, rd, ackd);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      logic ackd;
      xfer(1'b0, a, 32'h0, 4'hF, v, ackd);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic cleanup();
      wr(A_CTRL, 32'h0);
      wr(A_PRE, 32'h0);
      wr(A_COUNT, 32'h0);
      for (int ch = 0; ch < 4; ch++) begin
         wr(a_cmp(ch), 32'hFFFF_0000);
         wr(a_int(ch), 32'h0);
      end
      wr(A_STATUS, 32'hF);
   endtask

   task automatic test_reset();
      logic [31:0] v; logic ackd;
      n_tests++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", bus.ack); end
      n_tests++; if (bus.dat_s !== 32'h0) begin n_fail++; $display("FAIL rst_dat: got %h want 0", bus.dat_s); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", irq); end
      n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL stall: got %b want 0", bus.stall); end
      rst_i = 1'b1;
      idle(1);
      for (int a = 0; a <= 32'h30; a += 4) begin
         xfer(1'b0, 32'(a), 32'h0, 4'hF, v, ackd);
         n_tests++; if (ackd !== 1'b1) begin n_fail++; $display("FAIL reset_ack@%h: got %b want 1", a, ackd); end
         n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_read@%h: got %h want 0", a, v); end
      end
      idle(1);
      n_tests++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL ack_one_cycle: got %b want 0", bus.ack); end
   endtask

   // After k enabled edges: COUNT = k/(P+1); flag set once k >= CMP*(P+1); irq one edge later.
   task automatic test_oneshot(input int ch, input int p, input int c);
      logic [31:0] v, e;
      int match_k, n;
      cleanup();
      match_k = c * (p + 1);
      n = match_k + 4;
      wr(A_PRE, 32'(p));
      wr(a_cmp(ch), 32'(c));
      wr(A_CTRL, 32'h1 | (32'h1 << (4 + ch)));
      for (int i = 1; i <= n; i++) begin
         if (i % 2 == 1) begin
            rd(A_COUNT, v); e = 32'((i - 1) / (p + 1));
            n_tests++; if (v !== e) begin n_fail++; $display("FAIL oneshot_count k=%0d: got %h want %h", i - 1, v, e); end
         end else begin
            rd(A_STATUS, v); e = ((i - 1) >= match_k) ? (32'h1 << ch) : 32'h0;
            n_tests++; if (v !== e) begin n_fail++; $display("FAIL oneshot_flag k=%0d: got %h want %h", i - 1, v, e); end
         end
         n_tests++; if (irq !== (i >= match_k + 1)) begin n_fail++; $display("FAIL oneshot_irq k=%0d: got %b want %b", i, irq, (i >= match_k + 1)); end
      end
      wr(A_STATUS, 32'h1 << ch);
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL clr_irq_edge0: got %b want 1", irq); end
      idle(1);
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL clr_irq_edge1: got %b want 0", irq); end
      rd(A_STATUS, v);
      n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL clr_status: got %h want 0", v); end
   endtask

   // P=0, so COUNT = k; matches at c, c+iv, c+2iv, ...
   task automatic test_periodic(input int ch, input int c, input int iv, input int n);
      logic [31:0] v, e;
      int k, m;
      cleanup();
      wr(a_int(ch), 32'(iv));
      wr(a_cmp(ch), 32'(c));
      wr(A_CTRL, 32'h1 | (32'h1 << (8 + ch)));
      for (int i = 1; i <= n; i++) begin
         k = i - 1;
         m = (k >= c) ? 1 + (k - c) / iv : 0;
         if (i % 2 == 1) begin
            rd(a_cmp(ch), v); e = 32'(c + iv * m);
            n_tests++; if (v !== e) begin n_fail++; $display("FAIL periodic_cmp k=%0d: got %h want %h", k, v, e); end
         end else begin
            rd(A_STATUS, v); e = (m > 0) ? (32'h1 << ch) : 32'h0;
            n_tests++; if (v !== e) begin n_fail++; $display("FAIL periodic_flag k=%0d: got %h want %h", k, v, e); end
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] v, e;
      cleanup();
      wr(A_COUNT, 32'hFFFF_FFFE);
      wr(a_cmp(2), 32'h0);
      wr(A_CTRL, 32'h1 | (32'h1 << 6));
      for (int i = 1; i <= 6; i++) begin
         if (i % 2 == 1 || i == 2) begin
            rd(A_COUNT, v); e = 32'hFFFF_FFFE + 32'(i - 1);
            n_tests++; if (v !== e) begin n_fail++; $display("FAIL wrap_count k=%0d: got %h want %h", i - 1, v, e); end
         end else begin
            rd(A_STATUS, v); e = ((i - 1) >= 2) ? 32'h4 : 32'h0;
            n_tests++; if (v !== e) begin n_fail++; $display("FAIL wrap_flag k=%0d: got %h want %h", i - 1, v, e); end
         end
      end
   endtask

   task automatic test_collisions();
      logic [31:0] v;
      int c;
      cleanup();
      c = int'($urandom_range(3, 8));
      wr(a_cmp(0), 32'(c));
      wr(A_CTRL, 32'h11);
      idle(c - 1);
      wr(A_STATUS, 32'h1);
      rd(A_STATUS, v);
      n_tests++; if (v !== 32'h1) begin n_fail++; $display("FAIL clear_vs_set: got %h want 1", v); end
      wr(A_STATUS, 32'h1);
      rd(A_STATUS, v);
      n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL late_clear: got %h want 0", v); end
      wr(A_COUNT, 32'd100);
      rd(A_COUNT, v);
      n_tests++; if (v !== 32'd100) begin n_fail++; $display("FAIL count_wr_vs_tick: got %h want %h", v, 32'd100); end
      rd(A_COUNT, v);
      n_tests++; if (v !== 32'd101) begin n_fail++; $display("FAIL count_after_wr: got %h want %h", v, 32'd101); end

      cleanup();
      c = int'($urandom_range(3, 8));
      wr(a_int(3), 32'd7);
      wr(a_cmp(3), 32'(c));
      wr(A_CTRL, 32'h1 | (32'h1 << 11));
      idle(c - 1);
      wr(a_cmp(3), 32'h1234);
      rd(a_cmp(3), v);
      n_tests++; if (v !== 32'h1234) begin n_fail++; $display("FAIL cmp_wr_vs_reload: got %h want 1234", v); end
      rd(A_STATUS, v);
      n_tests++; if (v !== 32'h8) begin n_fail++; $display("FAIL reload_flag: got %h want 8", v); end

      cleanup();
      wr(A_CTRL, 32'h1);
      wr(A_CTRL, 32'h0);
      rd(A_COUNT, v);
      n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL en_clear_no_tick: got %h want 0", v); end
      idle(3);
      rd(A_COUNT, v);
      n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL en_off_hold: got %h want 0", v); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [4];
      logic [31:0] v;
      cleanup();
      for (int i = 0; i < 4; i++) begin
         vals[i] = $urandom;
         wr(a_cmp(i), vals[i]);
      end
      bus.cyc = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.stb = 1'b1; bus.we = 1'b0; bus.sel = 4'hF; bus.adr = a_cmp(i);
         @(posedge clk_i); #1;
         $display("[TB] RD burst adr=%h -> ack=%b dat_s=%h", bus.adr, bus.ack, bus.dat_s);
         n_tests++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack%0d: got %b want 1", i, bus.ack); end
         n_tests++; if (bus.dat_s !== vals[i]) begin n_fail++; $display("FAIL b2b_dat%0d: got %h want %h", i, bus.dat_s, vals[i]); end
      end
      bus.stb = 1'b0;
      @(posedge clk_i); #1;
      n_tests++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL b2b_extra_ack: got %b want 0", bus.ack); end
      bus.cyc = 1'b0;
   endtask

   task automatic test_byte_lanes();
      logic [31:0] v; logic ackd;
      wr(a_cmp(0), 32'h0);
      xfer(1'b1, a_cmp(0), 32'hAABB_CCDD, 4'b0010, v, ackd);
      n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL wr_dat_zero: got %h want 0", v); end
      rd(a_cmp(0), v);
      n_tests++; if (v !== 32'h0000_CC00) begin n_fail++; $display("FAIL byte_lane: got %h want 0000cc00", v); end
   endtask

   task automatic test_cyc_drop();
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = A_COUNT; bus.sel = 4'hF;
      @(posedge clk_i); #1;
      n_tests++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL drop_first_ack: got %b want 1", bus.ack); end
      bus.cyc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1;
         n_tests++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL stray_ack%0d: got %b want 0", i, bus.ack); end
      end
      bus.stb = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] v; logic ackd;
      cleanup();
      wr(a_cmp(0), 32'd2);
      wr(A_CTRL, 32'h11);
      idle(5);
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = A_COUNT;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      #1;
      n_tests++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ack: got %b want 0", bus.ack); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_rst_irq: got %b want 0", irq); end
      n_tests++; if (bus.dat_s !== 32'h0) begin n_fail++; $display("FAIL mid_rst_dat: got %h want 0", bus.dat_s); end
      bus.cyc = 1'b0; bus.stb = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      xfer(1'b0, A_COUNT, 32'h0, 4'hF, v, ackd);
      n_tests++; if (ackd !== 1'b1) begin n_fail++; $display("FAIL post_rst_ack: got %b want 1", ackd); end
      n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL post_rst_count: got %h want 0", v); end
      rd(A_CTRL, v);
      n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL post_rst_ctrl: got %h want 0", v); end
      rd(a_cmp(0), v);
      n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL post_rst_cmp0: got %h want 0", v); end
   endtask

   initial begin
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
      bus.adr = '0; bus.dat_m = '0; bus.sel = '0;
      repeat (3) @(posedge clk_i);
      #1;
      test_reset();
      test_oneshot(0, 3, 5);
      test_oneshot(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
      test_periodic(1, 10, 10, 34);
      test_periodic(int'($urandom_range(0, 3)), int'($urandom_range(2, 6)), int'($urandom_range(2, 5)), 24);
      test_wrap();
      test_collisions();
      test_back_to_back();
      test_byte_lanes();
      test_cyc_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_timer.md
# wb_timer

Wishbone pipelined slave timer/compare unit that hangs off one peripheral port of the `mmu` address decoder (one 256 MB window) and drives a level interrupt into one of the `bexkat2` `inter[2:0]` lines. It provides:

- a prescaled free-running 32-bit counter;
- up to four compare channels, each with an optional periodic reload interval;
- sticky match flags with per-channel interrupt enables.

## Interface

Parameters:
- `NCHAN`, 4: number of compare channels, 1..4.
- `PWIDTH`, 16: prescaler width in bits, 1..32.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, asynchronous and active-low; all state is cleared while it is low.
- `bus` if_wb.slave: Wishbone pipelined slave. It uses the members `adr`, `cyc`, `stb`, `we`, `sel`, `dat_m`, `dat_s`, `ack` and `stall`.
- `irq` out 1: level interrupt, high while any enabled flag is set.

## Operation

Register map is decoded on `adr[5:2]`, 32-bit words:
- 0x00 STATUS: [NCHAN-1:0] match flags. Write 1 to clear a flag.
- 0x04 CTRL: [0] EN, [7:4] IE per channel, [11:8] PER (periodic) per channel.
- 0x08 PRESCALE: [PWIDTH-1:0] divider P.
- 0x0C COUNT: counter value, read/write.
- 0x10–0x1C: CMP0–3.
- 0x20–0x2C: INTERVAL0–3.

Register access rules:
- Unmapped offsets, and channels at index ≥ NCHAN, read as 0. Writes to them are ignored but still acked.
- Writes honour `sel` byte lanes on every register. For STATUS, only the selected lanes clear.

Counter and prescaler:
- While EN=1, the prescale counter `pc` counts 0..P and then wraps. A tick is the cycle in which `pc==P`.
- On a tick, COUNT <= COUNT+1, wrapping modulo 2^32.
- While EN=0, `pc` is held at 0 and COUNT is held.
- P=0 means a tick every cycle.

Match behaviour:
- On a tick, channel n matches when `COUNT+1 == CMPn`.
- A match sets flag n in the same edge as the COUNT update.
- If PER[n]=1, the same edge also does CMPn <= CMPn + INTERVALn, modulo 2^32.
- A software write to COUNT or CMPn never creates a match by itself.

Interrupt output:
- `irq` is registered: `irq <= |(flags & IE)`.

Simultaneous events:
- Match and a STATUS clear of the same flag in the same cycle: the set wins.
- Software write to CMPn and a periodic reload of channel n in the same cycle: the software value wins. The flag still sets.
- Software write to COUNT and a tick in the same cycle: the written value wins, and `pc` resets to 0.
- Software clear of EN: `pc` resets to 0 on that edge. No tick occurs in that cycle.

## Timing

Bus handshake:
- `stall` is tied to 0, so a request is accepted in every cycle where `cyc && stb`.
- `ack` is asserted exactly one cycle after acceptance, for one cycle per accepted request.
- Back-to-back requests produce back-to-back acks.
- `dat_s` is registered and valid in the `ack` cycle. It is 0 for writes.
- A write takes effect at the accepting edge. A read in the following cycle returns the new value.
- If `cyc` drops, pending acks are discarded: the ack register clears when `cyc`=0.

Latency:
- Match edge → flag set: 0 cycles (the same edge).
- Flag set → `irq` high: one cycle.
- STATUS clear → `irq` low: one cycle after the write is accepted.

Reset values (rst_i low): `ack`=0, `dat_s`=0, `irq`=0, `pc`=0. STATUS, CTRL, PRESCALE, COUNT, CMPn and INTERVALn are all 0.

Reset mid-operation: all state, including an in-flight ack, clears immediately. The first access after reset release is serviced normally.

## Structure

- Package `wb_timer_pkg` holds:
  - register offset constants (`REG_STATUS` … `REG_INTERVAL0`);
  - CTRL bit positions and field ranges;
  - `MAX_CHAN=4`;
  - a `chan_t` struct containing `cmp`, `interval`, `flag`, `ie` and `per`.
- Sub-module `wb_timer_chan`, instantiated NCHAN times:
  - holds CMP, INTERVAL and the flag;
  - inputs: tick, `count_next`, write strobes and byte lanes, clear strobe;
  - output: flag.
- The top module holds the Wishbone decode, the read mux, the prescaler, COUNT and the `irq` register.

## Test plan

1. **Reset and read-back.** Hold `rst_i` low, then release it. Read every offset: all return 0, and each ack arrives exactly one cycle after its stb. Unmapped offset 0x30 reads 0.
2. **One-shot match.** Set PRESCALE=3, CMP0=5, IE0=1, EN=1. Expect COUNT=5 and flag0 set at cycle 20 after EN, with `irq` high one cycle later. Write STATUS=0x1: `irq` is low one cycle after acceptance.
3. **Periodic channel.** Set P=0, CMP1=10, INTERVAL1=10, PER1=1. Expect flag1 edges at COUNT=10, 20 and 30. CMP1 reads 40 after the third match.
4. **Wrap-around.** Write COUNT=0xFFFFFFFE, CMP2=0, P=0. Expect COUNT to go 0xFFFFFFFF, then 0, with flag2 set on the wrap tick.
5. **Collisions.** Clear STATUS bit 0 in the match cycle: the flag stays 1. Write COUNT=100 during a tick: COUNT reads 100, not old+1. Write CMP3 during a periodic reload: the written value persists.
6. **Bus pipeline and byte lanes.** Issue 4 back-to-back requests with `stall`=0: expect 4 consecutive acks. Write CMP0 with `sel`=0b0010 and `dat_m`=0xAABBCCDD over CMP0=0: CMP0 reads 0x0000CC00. Drop `cyc` mid-burst: no stray acks follow.
